// File: rtl/ex_alu_unit_if.sv
// Execute-stage bus: ID/EX operands, forwarding selects and enable in, ALU/EX-MEM results out.
// The master modport drives the pipeline side; the slave modport is the ALU unit.
interface ex_alu_unit_if;
   logic        enable;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] decode_a;
   logic [31:0] decode_b;
   logic [31:0] ex_mem_alu_out;
   logic [31:0] mem_wb_value;
   logic        byp_a_mem;
   logic        byp_a_alu_wb;
   logic        byp_a_ld_wb;
   logic        byp_b_mem;
   logic        byp_b_alu_wb;
   logic        byp_b_ld_wb;
   logic [31:0] alu_out;
   logic [31:0] alu_result_q;
   logic [31:0] store_data_q;
   logic        branch_taken_q;

   modport master (
      output enable, opcode, funct3, funct7, instruction, pc, decode_a, decode_b,
             ex_mem_alu_out, mem_wb_value, byp_a_mem, byp_a_alu_wb, byp_a_ld_wb,
             byp_b_mem, byp_b_alu_wb, byp_b_ld_wb,
      input  alu_out, alu_result_q, store_data_q, branch_taken_q
   );

   modport slave (
      input  enable, opcode, funct3, funct7, instruction, pc, decode_a, decode_b,
             ex_mem_alu_out, mem_wb_value, byp_a_mem, byp_a_alu_wb, byp_a_ld_wb,
             byp_b_mem, byp_b_alu_wb, byp_b_ld_wb,
      output alu_out, alu_result_q, store_data_q, branch_taken_q
   );
endinterface

// File: rtl/ex_alu_unit.sv
// RV32I execute stage: operand forwarding, immediate select, ALU, branch compare, EX/MEM register.
// Define ALU_MUL_EN to add RV32M MUL/MULH/MULHSU/MULHU; otherwise funct7=0000001 R-type yields 0.
module ex_alu_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic          i_clock,
   input logic          i_reset,
   ex_alu_unit_if.slave bus
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   logic [XLEN-1:0] w_fwd_a;
   logic [XLEN-1:0] w_fwd_b;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_ain;
   logic [XLEN-1:0] w_bin;
   logic [4:0]      w_shamt;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_mul_res;
   logic            w_branch;
   logic            w_unused;

   logic [XLEN-1:0] r_alu_result;
   logic [XLEN-1:0] r_store_data;
   logic            r_branch_taken;

   // The EX/MEM slot outranks MEM/WB because it holds the younger result.
   assign w_fwd_a = bus.byp_a_mem                        ? bus.ex_mem_alu_out :
                    (bus.byp_a_alu_wb | bus.byp_a_ld_wb) ? bus.mem_wb_value   : bus.decode_a;
   assign w_fwd_b = bus.byp_b_mem                        ? bus.ex_mem_alu_out :
                    (bus.byp_b_alu_wb | bus.byp_b_ld_wb) ? bus.mem_wb_value   : bus.decode_b;

   assign w_imm_i = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
   assign w_imm_s = {{20{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]};
   assign w_imm_u = {bus.instruction[31:12], 12'b0};

   always_comb begin
      w_ain = w_fwd_a;
      case (bus.opcode)
         OpLui:                  w_ain = '0;
         OpAuipc, OpJal, OpJalr: w_ain = bus.pc;
         default:                w_ain = w_fwd_a;
      endcase
   end

   always_comb begin
      w_bin = w_fwd_b;
      case (bus.opcode)
         OpReg, OpBranch: w_bin = w_fwd_b;
         OpImm, OpLoad:   w_bin = w_imm_i;
         OpStore:         w_bin = w_imm_s;
         OpLui, OpAuipc:  w_bin = w_imm_u;
         OpJal, OpJalr:   w_bin = XLEN'(4);
         default:         w_bin = w_fwd_b;
      endcase
   end

   assign w_shamt = w_bin[4:0];

`ifdef ALU_MUL_EN
   logic signed [XLEN:0]     w_mul_a;
   logic signed [XLEN:0]     w_mul_b;
   logic signed [2*XLEN+1:0] w_prod;

   // One signed 33x33 multiplier covers all four variants by choosing the extension bit.
   assign w_mul_a   = {(bus.funct3[1:0] != 2'b11) & w_fwd_a[XLEN-1], w_fwd_a};
   assign w_mul_b   = {~bus.funct3[1] & w_fwd_b[XLEN-1], w_fwd_b};
   assign w_prod    = w_mul_a * w_mul_b;
   assign w_mul_res = bus.funct3[2]               ? '0 :
                      (bus.funct3[1:0] == 2'b00)  ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   assign w_unused  = ^{bus.instruction[6:0], w_prod[2*XLEN+1:2*XLEN]};
`else
   assign w_mul_res = '0;
   assign w_unused  = ^bus.instruction[6:0];
`endif

   always_comb begin
      w_alu = '0;
      case (bus.opcode)
         OpReg, OpImm: begin
            if (bus.opcode == OpReg && bus.funct7 == 7'b0000001) begin
               w_alu = w_mul_res;
            end else begin
               case (bus.funct3)
                  3'b000: w_alu = (bus.opcode == OpReg && bus.funct7[5]) ? w_ain - w_bin
                                                                         : w_ain + w_bin;
                  3'b001: w_alu = w_ain << w_shamt;
                  3'b010: w_alu = {{(XLEN-1){1'b0}}, $signed(w_ain) < $signed(w_bin)};
                  3'b011: w_alu = {{(XLEN-1){1'b0}}, w_ain < w_bin};
                  3'b100: w_alu = w_ain ^ w_bin;
                  3'b101: w_alu = bus.funct7[5] ? $unsigned($signed(w_ain) >>> w_shamt)
                                                : w_ain >> w_shamt;
                  3'b110: w_alu = w_ain | w_bin;
                  default: w_alu = w_ain & w_bin;
               endcase
            end
         end
         OpLoad, OpStore, OpLui, OpAuipc, OpJal, OpJalr: w_alu = w_ain + w_bin;
         OpBranch: w_alu = w_fwd_a - w_fwd_b;
         default:  w_alu = '0;
      endcase
   end

   always_comb begin
      w_branch = 1'b0;
      if (bus.opcode == OpBranch) begin
         case (bus.funct3)
            3'b000:  w_branch = (w_fwd_a == w_fwd_b);
            3'b001:  w_branch = (w_fwd_a != w_fwd_b);
            3'b100:  w_branch = ($signed(w_fwd_a) < $signed(w_fwd_b));
            3'b101:  w_branch = ($signed(w_fwd_a) >= $signed(w_fwd_b));
            3'b110:  w_branch = (w_fwd_a < w_fwd_b);
            3'b111:  w_branch = (w_fwd_a >= w_fwd_b);
            default: w_branch = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_alu_result   <= '0;
         r_store_data   <= '0;
         r_branch_taken <= 1'b0;
      end else if (bus.enable) begin
         r_alu_result   <= w_alu;
         r_store_data   <= w_fwd_b;
         r_branch_taken <= w_branch;
      end
   end

   assign bus.alu_out        = w_alu;
   assign bus.alu_result_q   = r_alu_result;
   assign bus.store_data_q   = r_store_data;
   assign bus.branch_taken_q = r_branch_taken;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed ISA vectors, forwarding, reset/stall and random
// R-type ops; registered results are checked against a scoreboard queue one edge later.
module tb_ex_alu_unit;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

`ifdef ALU_MUL_EN
   localparam bit MulOn = 1'b1;
`else
   localparam bit MulOn = 1'b0;
`endif

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] da;
      logic [31:0] db;
      logic [31:0] exm;
      logic [31:0] mwb;
      logic [2:0]  ba;
      logic [2:0]  bb;
      logic [31:0] exp_alu;
      logic [31:0] exp_st;
      logic        exp_br;
   } vec_t;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] st;
      logic        br;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   string tag_q[$];
   exp_t model;

   always #5 clk = ~clk;

   ex_alu_unit_if bus ();

   ex_alu_unit #(.XLEN(32)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, want);
      end
   endtask

   // Registered outputs captured at the previous rising edge are compared here.
   always @(negedge clk) begin
      exp_t  e;
      string t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq({t, "/alu_q"}, bus.alu_result_q, e.alu);
         check_eq({t, "/store_q"}, bus.store_data_q, e.st);
         check_eq({t, "/br_q"}, {31'b0, bus.branch_taken_q}, {31'b0, e.br});
      end
   end

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] instr, input logic [31:0] da,
                               input logic [31:0] db, input logic [31:0] ea, input logic eb);
      vec_t v;
      v.op = op;  v.f3 = f3;  v.f7 = f7;  v.instr = instr;
      v.pc = '0;  v.da = da;  v.db = db;  v.exm = '0;  v.mwb = '0;
      v.ba = '0;  v.bb = '0;  v.exp_alu = ea;  v.exp_st = db;  v.exp_br = eb;
      return v;
   endfunction

   function automatic logic [31:0] imm_i(input logic [11:0] imm);
      return {imm, 20'h0};
   endfunction

   function automatic logic [31:0] imm_s(input logic [11:0] imm);
      return {imm[11:5], 13'h0, imm[4:0], 7'h0};
   endfunction

   function automatic logic [31:0] ref_r(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic drive(input string tag, input vec_t v, input logic rst, input logic en);
      @(negedge clk);
      rst_n = rst;
      bus.enable = en;
      bus.opcode = v.op;
      bus.funct3 = v.f3;
      bus.funct7 = v.f7;
      bus.instruction = v.instr;
      bus.pc = v.pc;
      bus.decode_a = v.da;
      bus.decode_b = v.db;
      bus.ex_mem_alu_out = v.exm;
      bus.mem_wb_value = v.mwb;
      {bus.byp_a_mem, bus.byp_a_alu_wb, bus.byp_a_ld_wb} = v.ba;
      {bus.byp_b_mem, bus.byp_b_alu_wb, bus.byp_b_ld_wb} = v.bb;
      #1;
      check_eq({tag, "/alu_out"}, bus.alu_out, v.exp_alu);
      if (!rst) begin
         model.alu = '0;  model.st = '0;  model.br = 1'b0;
      end else if (en) begin
         model.alu = v.exp_alu;  model.st = v.exp_st;  model.br = v.exp_br;
      end
      exp_q.push_back(model);
      tag_q.push_back(tag);
   endtask

   initial begin
      vec_t        v;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic [6:0]  f7;

      rst_n = 1'b0;
      model.alu = '0;  model.st = '0;  model.br = 1'b0;

      // Reset holds the registers at zero even with enable high.
      v = mk(OpReg, 3'b000, 7'h00, '0, 32'd5, 32'd3, 32'd10, 1'b0);
      v.ba = 3'b100;  v.exm = 32'd7;
      drive("rst0", v, 1'b0, 1'b1);
      drive("rst1", v, 1'b0, 1'b1);
      drive("add_fwd", v, 1'b1, 1'b1);

      v = mk(OpReg, 3'b000, 7'h00, '0, 32'd50, 32'd100, 32'd3, 1'b0);
      v.ba = 3'b101;  v.bb = 3'b001;  v.exm = 32'd1;  v.mwb = 32'd2;  v.exp_st = 32'd2;
      drive("prio", v, 1'b1, 1'b1);

      drive("sub", mk(OpReg, 3'b000, 7'h20, '0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0), 1'b1, 1'b1);
      drive("srai", mk(OpImm, 3'b101, 7'h20, imm_i(12'h404), 32'h8000_0000, 32'h1234,
                       32'hF800_0000, 1'b0), 1'b1, 1'b1);
      drive("srli", mk(OpImm, 3'b101, 7'h00, imm_i(12'h004), 32'h8000_0000, 32'h1234,
                       32'h0800_0000, 1'b0), 1'b1, 1'b1);
      drive("sltu", mk(OpReg, 3'b011, 7'h00, '0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0), 1'b1, 1'b1);
      drive("slt", mk(OpReg, 3'b010, 7'h00, '0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0), 1'b1, 1'b1);
      drive("sll", mk(OpReg, 3'b001, 7'h00, '0, 32'd1, 32'h23, 32'd8, 1'b0), 1'b1, 1'b1);
      drive("xor", mk(OpReg, 3'b100, 7'h00, '0, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115,
                      1'b0), 1'b1, 1'b1);
      drive("or", mk(OpReg, 3'b110, 7'h00, '0, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFFF0_5335,
                     1'b0), 1'b1, 1'b1);
      drive("and", mk(OpReg, 3'b111, 7'h00, '0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h00F0_0220,
                      1'b0), 1'b1, 1'b1);
      drive("addi", mk(OpImm, 3'b000, 7'h20, imm_i(12'hFFF), 32'd10, 32'd77, 32'd9, 1'b0),
            1'b1, 1'b1);
      drive("load", mk(OpLoad, 3'b010, 7'h00, imm_i(12'h800), 32'h1000, 32'd0, 32'h800, 1'b0),
            1'b1, 1'b1);

      v = mk(OpStore, 3'b010, 7'h7F, imm_s(12'hFFC), 32'h2000, 32'h55, 32'h1FFC, 1'b0);
      v.bb = 3'b010;  v.mwb = 32'hDEAD_BEEF;  v.exp_st = 32'hDEAD_BEEF;
      drive("store", v, 1'b1, 1'b1);

      drive("lui", mk(OpLui, 3'b000, 7'h00, 32'h1234_5000, 32'hAAAA, 32'd0, 32'h1234_5000, 1'b0),
            1'b1, 1'b1);
      v = mk(OpAuipc, 3'b000, 7'h00, 32'h0000_1000, 32'hAAAA, 32'd0, 32'h1100, 1'b0);
      v.pc = 32'h100;
      drive("auipc", v, 1'b1, 1'b1);
      v = mk(OpJal, 3'b000, 7'h00, 32'h0100_0000, 32'hAAAA, 32'd0, 32'h204, 1'b0);
      v.pc = 32'h200;
      drive("jal", v, 1'b1, 1'b1);
      v = mk(OpJalr, 3'b000, 7'h00, imm_i(12'h010), 32'd5, 32'd0, 32'h304, 1'b0);
      v.pc = 32'h300;
      drive("jalr", v, 1'b1, 1'b1);

      drive("blt", mk(OpBranch, 3'b100, 7'h00, '0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1),
            1'b1, 1'b1);
      drive("bltu", mk(OpBranch, 3'b110, 7'h00, '0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0),
            1'b1, 1'b1);
      drive("beq", mk(OpBranch, 3'b000, 7'h00, '0, 32'd7, 32'd7, 32'd0, 1'b1), 1'b1, 1'b1);
      drive("bne_eq", mk(OpBranch, 3'b001, 7'h00, '0, 32'd7, 32'd7, 32'd0, 1'b0), 1'b1, 1'b1);
      drive("bge", mk(OpBranch, 3'b101, 7'h00, '0, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b1), 1'b1, 1'b1);
      drive("bgeu", mk(OpBranch, 3'b111, 7'h00, '0, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b0),
            1'b1, 1'b1);
      drive("br010", mk(OpBranch, 3'b010, 7'h00, '0, 32'd7, 32'd7, 32'd0, 1'b0), 1'b1, 1'b1);
      drive("unk_op", mk(7'h7F, 3'b000, 7'h00, '0, 32'd9, 32'd4, 32'd0, 1'b0), 1'b1, 1'b1);

      drive("mulhu", mk(OpReg, 3'b011, 7'h01, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        MulOn ? 32'hFFFF_FFFE : 32'd0, 1'b0), 1'b1, 1'b1);
      drive("mul", mk(OpReg, 3'b000, 7'h01, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      MulOn ? 32'd1 : 32'd0, 1'b0), 1'b1, 1'b1);
      drive("mulhsu", mk(OpReg, 3'b010, 7'h01, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                         MulOn ? 32'hFFFF_FFFF : 32'd0, 1'b0), 1'b1, 1'b1);
      drive("mulh", mk(OpReg, 3'b001, 7'h01, '0, 32'h8000_0000, 32'd2,
                       MulOn ? 32'hFFFF_FFFF : 32'd0, 1'b0), 1'b1, 1'b1);
      drive("mulhu2", mk(OpReg, 3'b011, 7'h01, '0, 32'h8000_0000, 32'd2,
                         MulOn ? 32'd1 : 32'd0, 1'b0), 1'b1, 1'b1);
      drive("div", mk(OpReg, 3'b100, 7'h01, '0, 32'd100, 32'd5, 32'd0, 1'b0), 1'b1, 1'b1);

      v = mk(OpBranch, 3'b001, 7'h00, '0, 32'd5, 32'd5, 32'hFFFF_FFFF, 1'b1);
      v.bb = 3'b010;  v.mwb = 32'd6;  v.exp_st = 32'd6;
      drive("bne_fwd", v, 1'b1, 1'b1);

      // Stall: registers keep the bne_fwd capture while new operands are presented.
      v = mk(OpReg, 3'b000, 7'h00, '0, 32'd1, 32'd1, 32'd2, 1'b0);
      drive("hold0", v, 1'b1, 1'b0);
      drive("hold1", v, 1'b1, 1'b0);
      drive("rst_en", v, 1'b0, 1'b1);
      drive("post_rst", v, 1'b1, 1'b1);

      for (int i = 0; i < 24; i++) begin
         a  = $urandom;
         b  = $urandom;
         f3 = 3'($urandom_range(0, 7));
         f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         drive("rand", mk(OpReg, f3, f7, '0, a, b, ref_r(f3, f7[5], a, b), 1'b0), 1'b1, 1'b1);
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
